// File: rtl/adc_avg_filter.sv
// Moving-average filter for a 10-bit ADC stream: mean of the last 2^LOG2N samples,
// updated once per rising edge of data_valid_in.
module adc_avg_filter #(
    parameter int LOG2N = 3
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [9:0] data_in,
    input  logic       data_valid_in,
    input  logic       clear,
    output logic [9:0] data_out,
    output logic       data_valid_out,
    output logic       filled
);

    localparam int N     = 1 << LOG2N;
    localparam int SUM_W = 10 + LOG2N;
    localparam logic [LOG2N:0] FILL_MAX = (LOG2N + 1)'(N);

    logic [9:0]       r_buf [N];
    logic [LOG2N-1:0] r_wptr;
    logic [SUM_W-1:0] r_sum;
    logic [LOG2N:0]   r_fill;
    logic             r_dv_q;
    logic [9:0]       r_data_out;
    logic             r_data_valid_out;

    logic             w_accept;
    logic [SUM_W-1:0] w_sum_next;

    // The sum always contains the evicted entry, so the subtraction never underflows.
    assign w_accept   = data_valid_in & ~r_dv_q;
    assign w_sum_next = r_sum + SUM_W'(data_in) - SUM_W'(r_buf[r_wptr]);

    always_ff @(posedge sysclk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values; blocking would chain reads within the same edge.
        if (reset) begin
            // NOTE: the window buffer is explicitly zeroed because stale entries
            // would be subtracted from the sum once the pointer wraps.
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
            r_wptr           <= '0;
            r_sum            <= '0;
            r_fill           <= '0;
            r_dv_q           <= 1'b1;
            r_data_out       <= '0;
            r_data_valid_out <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
            r_wptr           <= '0;
            r_sum            <= '0;
            r_fill           <= '0;
            r_dv_q           <= data_valid_in;
            r_data_out       <= '0;
            r_data_valid_out <= 1'b0;
        end else begin
            r_dv_q           <= data_valid_in;
            r_data_valid_out <= w_accept;
            if (w_accept) begin
                r_buf[r_wptr] <= data_in;
                r_wptr        <= r_wptr + 1'b1;
                r_sum         <= w_sum_next;
                r_data_out    <= w_sum_next[SUM_W-1:LOG2N];
                if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_valid_out = r_data_valid_out;
    assign filled         = (r_fill == FILL_MAX);

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for adc_avg_filter (LOG2N=3): table-driven vectors plus hand-written
// sequences for clear collision, wrap-around and reset priority.
module tb_adc_avg_filter;

    typedef struct {
        string      name;
        logic       clr;
        logic       dv;
        logic [9:0] din;
        logic [9:0] exp_out;
        logic       exp_valid;
        logic       exp_filled;
    } vec_t;

    logic       sysclk = 1'b0;
    logic       reset;
    logic [9:0] data_in;
    logic       data_valid_in;
    logic       clear;
    logic [9:0] data_out;
    logic       data_valid_out;
    logic       filled;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    adc_avg_filter #(.LOG2N(3)) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .clear          (clear),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .filled         (filled)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check_outs(input string name, input int e_out, input int e_valid, input int e_filled);
        check({name, ".data_out"}, int'(data_out), e_out);
        check({name, ".valid"}, int'(data_valid_out), e_valid);
        check({name, ".filled"}, int'(filled), e_filled);
    endtask

    function automatic void add_vec(input string name, input logic clr, input logic dv,
                                    input logic [9:0] din, input logic [9:0] e_out,
                                    input logic e_valid, input logic e_filled);
        vec_t v;
        v.name = name; v.clr = clr; v.dv = dv; v.din = din;
        v.exp_out = e_out; v.exp_valid = e_valid; v.exp_filled = e_filled;
        vecs.push_back(v);
    endfunction

    // Applies one accept (rise then fall of data_valid_in) and checks the pulse.
    task automatic sample(input string name, input logic [9:0] din, input int e_out, input int e_filled);
        data_valid_in = 1'b1; data_in = din;
        tick();
        check_outs(name, e_out, 1, e_filled);
        data_valid_in = 1'b0; data_in = 10'h2AA;
        tick();
        check_outs({name, "_hold"}, e_out, 0, e_filled);
    endtask

    initial begin
        int win[8];
        int widx;
        int wsum;

        // Ramp: 8 samples of 800, data_in garbage while idle must be ignored.
        for (int k = 1; k <= 8; k++) begin
            add_vec($sformatf("ramp%0d", k), 1'b0, 1'b1, 10'd800, 10'(100 * k), 1'b1, 1'(k == 8));
            add_vec($sformatf("ramp%0d_idle", k), 1'b0, 1'b0, 10'd1023, 10'(100 * k), 1'b0, 1'(k == 8));
        end
        // Eviction: zeros push the 800s out one at a time.
        for (int k = 1; k <= 8; k++) begin
            add_vec($sformatf("evict%0d", k), 1'b0, 1'b1, 10'd0, 10'(800 - 100 * k), 1'b1, 1'b1);
            add_vec($sformatf("evict%0d_idle", k), 1'b0, 1'b0, 10'd555, 10'(800 - 100 * k), 1'b0, 1'b1);
        end
        // Clear to empty, then a 5-cycle high level yields one sample of 1023 -> 127.
        add_vec("clear_empty", 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
        add_vec("level1", 1'b0, 1'b1, 10'd1023, 10'd127, 1'b1, 1'b0);
        for (int k = 2; k <= 5; k++)
            add_vec($sformatf("level%0d", k), 1'b0, 1'b1, 10'd1023, 10'd127, 1'b0, 1'b0);
        add_vec("level_fall", 1'b0, 1'b0, 10'd1023, 10'd127, 1'b0, 1'b0);

        // Reset held 2 cycles with data_valid_in high.
        clear = 1'b0; data_in = 10'd0; data_valid_in = 1'b1; reset = 1'b1;
        tick();
        tick();
        check_outs("reset", 0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outs($sformatf("dv_held_after_reset%0d", k), 0, 0, 0);
        end
        data_valid_in = 1'b0;
        tick();
        check_outs("dv_drop", 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            clear = vecs[i].clr; data_valid_in = vecs[i].dv; data_in = vecs[i].din;
            tick();
            check_outs(vecs[i].name, int'(vecs[i].exp_out), int'(vecs[i].exp_valid),
                       int'(vecs[i].exp_filled));
        end
        clear = 1'b0;

        // Clear colliding with an accept: sample discarded, no pulse.
        clear = 1'b1; data_valid_in = 1'b1; data_in = 10'd500;
        tick();
        check_outs("clear_collide", 0, 0, 0);
        clear = 1'b0; data_valid_in = 1'b0;
        tick();
        check_outs("clear_collide_idle", 0, 0, 0);
        sample("after_clear", 10'd500, 62, 0);

        // Wrap-around: 20 samples i*50 against an independent sliding-window model.
        clear = 1'b1;
        tick();
        check_outs("wrap_clear", 0, 0, 0);
        clear = 1'b0;
        for (int k = 0; k < 8; k++) win[k] = 0;
        widx = 0;
        for (int i = 0; i < 20; i++) begin
            win[widx] = i * 50;
            widx = (widx + 1) % 8;
            wsum = 0;
            for (int k = 0; k < 8; k++) wsum += win[k];
            sample($sformatf("wrap%0d", i), 10'(i * 50), wsum / 8, int'(i >= 7));
        end
        check("wrap_final", int'(data_out), 775);

        // Reset wins over a simultaneous accept, mid-window.
        reset = 1'b1; data_valid_in = 1'b1; data_in = 10'd300;
        tick();
        check_outs("reset_mid_window", 0, 0, 0);
        reset = 1'b0; data_valid_in = 1'b0;
        tick();
        sample("post_reset", 10'd800, 100, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_avg_filter.md
ADC_AVG_FILTER -- requirements
Module: adc_avg_filter

Interface
REQ-001 SHALL have parameter LOG2N, default 3, meaning the averaging window is N = 2^LOG2N samples (legal range 1..4).
REQ-002 SHALL have port sysclk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port data_in, input, 10, unsigned ADC sample (spi2adc data_from_adc).
REQ-005 SHALL have port data_valid_in, input, 1, sample-ready level from spi2adc data_valid.
REQ-006 SHALL have port clear, input, 1, synchronous flush of the window.
REQ-007 SHALL have port data_out, output, 10, windowed mean of the most recent N samples.
REQ-008 SHALL have port data_valid_out, output, 1, one-cycle pulse marking a new data_out.
REQ-009 SHALL have port filled, output, 1, high once N samples are accepted since the last reset or clear.

Function
REQ-010 SHALL keep an N-entry circular buffer of 10-bit samples, a LOG2N-bit write pointer, a (10+LOG2N)-bit running sum, a fill counter saturating at N, and a registered copy dv_q of data_valid_in.
REQ-011 SHALL accept a sample only on the cycle where data_valid_in=1 and dv_q=0 (rising edge); a level held high for many cycles yields exactly one sample.
REQ-012 SHALL, on accept: sum <= sum + data_in - buf[wptr]; buf[wptr] <= data_in; wptr <= wptr+1 modulo N (N-1 wraps to 0).
REQ-013 SHALL, on the same accept edge, register data_out <= (updated sum) >> LOG2N (truncating) and data_valid_out <= 1; the result is visible in the cycle after the sample is presented (latency 1).
REQ-014 SHALL drive data_valid_out to 0 on every non-accept cycle; data_out holds its last value between accepts.
REQ-015 SHALL treat unfilled buffer entries as 0, so the mean ramps up during the first N samples (no division by fill count).
REQ-016 SHALL increment the fill counter on each accept until N, assert filled combinationally from the counter equal to N, and never deassert filled except via reset or clear.
REQ-017 SHALL never overflow the sum: max value N*1023 fits in 10+LOG2N bits.
REQ-018 SHALL, when clear=1: zero buffer, sum, wptr, fill counter, data_out and data_valid_out; dv_q still loads data_valid_in.
REQ-019 SHALL give clear priority over a simultaneous accept: the sample is discarded and no data_valid_out pulse occurs.
REQ-020 SHALL ignore data_in whenever no accept occurs.

Reset
REQ-021 SHALL, when reset=1, on the next edge set buffer, sum, wptr, fill counter, data_out = 0, data_valid_out = 0, filled = 0, and dv_q = 1.
REQ-022 SHALL, because dv_q resets to 1, not accept a sample when data_valid_in is held high across reset release; a fresh 0->1 transition is required.
REQ-023 SHALL give reset priority over clear and accept, including mid-window; all partially accumulated samples are lost.

Verification
REQ-024 SHALL verify reset: assert reset 2 cycles with data_valid_in=1 -> data_out=0, data_valid_out=0, filled=0; hold data_valid_in=1 after release -> no pulse.
REQ-025 SHALL verify ramp: LOG2N=3, 8 rising edges with data_in=800 -> data_out 100,200,...,800, one pulse each, filled rises with the 8th pulse.
REQ-026 SHALL verify eviction: after REQ-025, one sample of 0 -> data_out=700; 7 more zeros -> data_out=0, filled stays 1.
REQ-027 SHALL verify edge detection: data_valid_in high 5 cycles with data_in=1023 from empty -> exactly one pulse, data_out=127.
REQ-028 SHALL verify clear collision: clear=1 on the accept cycle of data_in=500 -> no pulse, data_out=0, filled=0; the next edge with 500 -> data_out=62.
REQ-029 SHALL verify wrap-around: 20 samples with values 0..19×50 -> each data_out equals the truncated mean of the last 8 samples (final: (600+...+950)/8 = 775).
